// File: rtl/tlu_dut_port.sv
// tlu_dut_port: trigger/handshake port from a trigger logic unit towards one DUT.
// Supports a fixed-length trigger pulse, a busy handshake, and a busy handshake
// with the trigger number shifted out serially on the DUT's own shift clock.
module tlu_dut_port #(
    parameter int TRIGGER_BITS = 15,
    parameter int TIMEOUT      = 255,
    parameter int PULSE_LEN    = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ENABLE,
    input  logic [1:0]              MODE,
    input  logic                    TRIGGER_IN,
    input  logic [TRIGGER_BITS-1:0] TRIGGER_ID,
    input  logic                    DUT_BUSY,
    input  logic                    DUT_CLOCK,
    output logic                    DUT_TRIGGER,
    output logic                    READY,
    output logic                    ACCEPTED,
    output logic                    SKIPPED,
    output logic                    TIMEOUT_FLAG,
    output logic [31:0]             TRIGGER_CNT
);

    localparam int BIT_W   = $clog2(TRIGGER_BITS + 1);
    localparam int TMO_W   = 16;
    localparam int PULSE_W = 8;

    // Counter terminal values, sized to their counters
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(TRIGGER_BITS);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PULSE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_SHIFT     = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers for the two asynchronous DUT inputs (bit 0 busy, bit 1 clock)
    // ------------------------------------------------------------------
    logic [1:0] async_in;
    logic [1:0] sync_lvl;

    assign async_in = {DUT_CLOCK, DUT_BUSY};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Two-flop synchronizer, cleared by reset
            always_ff @(posedge CLK) begin
                if (RST) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_lvl[gi] = sync_reg;
        end
    endgenerate

    logic busy_sync;
    logic dclk_sync;
    logic dclk_dly_reg;
    logic dclk_rise;
    logic dclk_fall;

    assign busy_sync = sync_lvl[0];
    assign dclk_sync = sync_lvl[1];

    // Third flop on the DUT clock path, used only for edge detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            dclk_dly_reg <= 1'b0;
        end else begin
            dclk_dly_reg <= dclk_sync;
        end
    end

    assign dclk_rise = dclk_sync & ~dclk_dly_reg;
    assign dclk_fall = ~dclk_sync & dclk_dly_reg;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t                    state_reg,    state_next;
    logic                      trig_reg,     trig_next;
    logic [TRIGGER_BITS-1:0]   id_reg,       id_next;
    logic [1:0]                mode_reg,     mode_next;
    logic [31:0]               cnt_reg,      cnt_next;
    logic [BIT_W-1:0]          bit_reg,      bit_next;
    logic [TMO_W-1:0]          tmo_reg,      tmo_next;
    logic [PULSE_W-1:0]        pulse_reg,    pulse_next;
    logic                      acc_reg,      acc_next;
    logic                      skip_reg,     skip_next;
    logic                      tflag_reg,    tflag_next;

    logic accept;
    logic tmo_hit;

    assign accept  = (state_reg == S_IDLE) & ENABLE & TRIGGER_IN & ~busy_sync;
    assign tmo_hit = (tmo_reg == TMO_LAST);

    // State register: every control register updates here, reset wins unconditionally
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= S_IDLE;
            trig_reg  <= 1'b0;
            id_reg    <= '0;
            mode_reg  <= 2'd0;
            cnt_reg   <= 32'd0;
            bit_reg   <= '0;
            tmo_reg   <= '0;
            pulse_reg <= '0;
            acc_reg   <= 1'b0;
            skip_reg  <= 1'b0;
            tflag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            trig_reg  <= trig_next;
            id_reg    <= id_next;
            mode_reg  <= mode_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            tmo_reg   <= tmo_next;
            pulse_reg <= pulse_next;
            acc_reg   <= acc_next;
            skip_reg  <= skip_next;
            tflag_reg <= tflag_next;
        end
    end

    // Next-state logic: transitions, counters and the registered DUT_TRIGGER value
    always_comb begin
        state_next = state_reg;
        trig_next  = trig_reg;
        id_next    = id_reg;
        mode_next  = mode_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        tmo_next   = tmo_reg;
        pulse_next = pulse_reg;
        acc_next   = 1'b0;
        skip_next  = TRIGGER_IN & ~accept;
        tflag_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    id_next    = TRIGGER_ID;
                    mode_next  = MODE;
                    acc_next   = 1'b1;
                    cnt_next   = cnt_reg + 32'd1;
                    trig_next  = 1'b1;
                    tmo_next   = '0;
                    pulse_next = '0;
                    bit_next   = '0;
                    state_next = (MODE == 2'd0) ? S_PULSE : S_WAIT_BUSY;
                end
            end

            S_PULSE: begin
                if (pulse_reg == PULSE_LAST) begin
                    trig_next  = 1'b0;
                    state_next = S_IDLE;
                end else begin
                    pulse_next = pulse_reg + PULSE_W'(1);
                end
            end

            S_WAIT_BUSY: begin
                if (busy_sync) begin
                    // Modes 2 and 3 both carry the trigger number
                    trig_next  = 1'b0;
                    tmo_next   = '0;
                    bit_next   = '0;
                    state_next = (mode_reg == 2'd1) ? S_WAIT_IDLE : S_SHIFT;
                end else if (tmo_hit) begin
                    trig_next  = 1'b0;
                    tflag_next = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end

            S_SHIFT: begin
                if (dclk_rise) begin
                    tmo_next = '0;
                    // Surplus rising edges after the last bit leave the line untouched
                    if (bit_reg < LAST_BIT) begin
                        trig_next = id_reg[bit_reg];
                        bit_next  = bit_reg + BIT_W'(1);
                    end
                end else if (dclk_fall) begin
                    tmo_next = '0;
                    if (bit_reg == LAST_BIT) begin
                        trig_next  = 1'b0;
                        state_next = S_WAIT_IDLE;
                    end
                end else if (tmo_hit) begin
                    trig_next  = 1'b0;
                    tflag_next = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end

            S_WAIT_IDLE: begin
                if (!busy_sync) begin
                    state_next = S_IDLE;
                end else if (tmo_hit) begin
                    trig_next  = 1'b0;
                    tflag_next = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end

            default: begin
                trig_next  = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: READY decoded from the registered state, everything else registered
    always_comb begin
        READY        = (state_reg == S_IDLE);
        DUT_TRIGGER  = trig_reg;
        ACCEPTED     = acc_reg;
        SKIPPED      = skip_reg;
        TIMEOUT_FLAG = tflag_reg;
        TRIGGER_CNT  = cnt_reg;
    end

endmodule
